// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared buffer-memory pointer width and counter constants
package mem_pkg;
  localparam int ADDR_W     = 12;
  localparam int DROP_CNT_W = 16;

  typedef logic [ADDR_W-1:0] ptr_t;
endpackage

// File: rtl/egress_ptr_queue_if.sv
// rtl/egress_ptr_queue_if.sv - push/pop/fanout bundle between translator, frame readers and egress queues
interface egress_ptr_queue_if
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 4
);
  localparam int FC_W = $clog2(NUM_PORTS + 1);

  logic [NUM_PORTS-1:0]        write_reqs_i;
  ptr_t [NUM_PORTS-1:0]        start_ptrs_i;
  logic [NUM_PORTS-1:0]        pop_i;
  ptr_t [NUM_PORTS-1:0]        ptr_o;
  logic [NUM_PORTS-1:0]        ptr_valid_o;
  logic [NUM_PORTS-1:0]        full_o;
  logic                        fanout_valid_o;
  ptr_t                        fanout_ptr_o;
  logic [FC_W-1:0]             fanout_cnt_o;

  modport master (
    output write_reqs_i, start_ptrs_i, pop_i,
    input  ptr_o, ptr_valid_o, full_o, fanout_valid_o, fanout_ptr_o, fanout_cnt_o
  );

  modport slave (
    input  write_reqs_i, start_ptrs_i, pop_i,
    output ptr_o, ptr_valid_o, full_o, fanout_valid_o, fanout_ptr_o, fanout_cnt_o
  );
endinterface

// File: rtl/egress_ptr_queue_fifo.sv
// rtl/egress_ptr_queue_fifo.sv - ptr_fifo: single-port show-ahead pointer FIFO for one egress port
module ptr_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  ptr_t din,
  output ptr_t dout,
  output logic valid,
  output logic full,
  output logic push_ok,
  output logic drop
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  ptr_t             mem [DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] count;
  logic             pop_ok;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && valid;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_idx <= wr_idx + IDX_W'(1);
      if (pop_ok)  rd_idx <= rd_idx + IDX_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_idx] <= din;
  end
endmodule

// File: rtl/egress_ptr_queue.sv
// rtl/egress_ptr_queue.sv - per-port egress pointer queues with fanout report
// Optional per-port drop counters enabled by EGRESS_DROP_CNT_EN.
module egress_ptr_queue
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 8
) (
  input logic                  clk,
  input logic                  rst,
  egress_ptr_queue_if.slave    q
`ifdef EGRESS_DROP_CNT_EN
  ,
  output logic [NUM_PORTS-1:0][DROP_CNT_W-1:0] drop_cnt_o
`endif
);
  localparam int FC_W = $clog2(NUM_PORTS + 1);

  logic [NUM_PORTS-1:0] push_ok;
  logic [NUM_PORTS-1:0] drop;
  logic [FC_W-1:0]      accept_cnt;
  ptr_t                 lead_ptr;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ptr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (q.write_reqs_i[p]),
      .pop     (q.pop_i[p]),
      .din     (q.start_ptrs_i[p]),
      .dout    (q.ptr_o[p]),
      .valid   (q.ptr_valid_o[p]),
      .full    (q.full_o[p]),
      .push_ok (push_ok[p]),
      .drop    (drop[p])
    );
  end

  // Walk high to low so the lowest-indexed requester wins the reported pointer.
  always_comb begin
    accept_cnt = '0;
    lead_ptr   = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      accept_cnt = accept_cnt + FC_W'(push_ok[p]);
      if (q.write_reqs_i[p]) lead_ptr = q.start_ptrs_i[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q.fanout_valid_o <= 1'b0;
      q.fanout_cnt_o   <= '0;
      q.fanout_ptr_o   <= '0;
    end else begin
      q.fanout_valid_o <= |q.write_reqs_i;
      q.fanout_cnt_o   <= accept_cnt;
      q.fanout_ptr_o   <= lead_ptr;
    end
  end

`ifdef EGRESS_DROP_CNT_EN
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rst) drop_cnt_o[p] <= '0;
      else if (drop[p] && drop_cnt_o[p] != '1) drop_cnt_o[p] <= drop_cnt_o[p] + DROP_CNT_W'(1);
    end
  end
`else
  logic unused_drop;
  assign unused_drop = ^drop;
`endif
endmodule

// File: tb/tb_egress_ptr_queue.sv
// tb/tb_egress_ptr_queue.sv - directed self-checking bench for egress_ptr_queue
module tb_egress_ptr_queue;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  egress_ptr_queue_if #(.NUM_PORTS(4)) q ();

`ifdef EGRESS_DROP_CNT_EN
  logic [3:0][DROP_CNT_W-1:0] drop_cnt;
`endif

  egress_ptr_queue #(.NUM_PORTS(4), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q)
`ifdef EGRESS_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 ns later, then return strobes to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    q.write_reqs_i = '0;
    q.pop_i        = '0;
  endtask

  initial begin
    q.write_reqs_i = '0;
    q.pop_i        = '0;
    q.start_ptrs_i = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_valid", 32'(q.ptr_valid_o), 32'h0);
    chk("reset_full", 32'(q.full_o), 32'h0);
    chk("reset_fvalid", 32'(q.fanout_valid_o), 32'h0);
    chk("reset_fcnt", 32'(q.fanout_cnt_o), 32'h0);
    chk("reset_fptr", 32'(q.fanout_ptr_o), 32'h0);
`ifdef EGRESS_DROP_CNT_EN
    chk("reset_drop0", 32'(drop_cnt[0]), 32'h0);
`endif

    // Single push to port 2
    q.write_reqs_i = 4'b0100;
    q.start_ptrs_i[2] = 12'h010;
    tick();
    chk("p2_valid", 32'(q.ptr_valid_o), 32'h4);
    chk("p2_head", 32'(q.ptr_o[2]), 32'h010);
    chk("p2_fvalid", 32'(q.fanout_valid_o), 32'h1);
    chk("p2_fcnt", 32'(q.fanout_cnt_o), 32'h1);
    chk("p2_fptr", 32'(q.fanout_ptr_o), 32'h010);
    q.pop_i = 4'b0100;
    tick();
    chk("p2_pop_valid", 32'(q.ptr_valid_o), 32'h0);
    chk("idle_fvalid", 32'(q.fanout_valid_o), 32'h0);

    // Flood all ports
    q.write_reqs_i = 4'b1111;
    for (int p = 0; p < 4; p++) q.start_ptrs_i[p] = 12'h020;
    tick();
    chk("flood_valid", 32'(q.ptr_valid_o), 32'hF);
    for (int p = 0; p < 4; p++) chk($sformatf("flood_head%0d", p), 32'(q.ptr_o[p]), 32'h020);
    chk("flood_fcnt", 32'(q.fanout_cnt_o), 32'h4);
    chk("flood_fptr", 32'(q.fanout_ptr_o), 32'h020);
    q.pop_i = 4'b1111;
    tick();
    chk("flood_drain", 32'(q.ptr_valid_o), 32'h0);

    // Lowest requesting port supplies the fanout pointer
    q.write_reqs_i = 4'b1010;
    q.start_ptrs_i[0] = 12'hAAA;
    q.start_ptrs_i[1] = 12'h111;
    q.start_ptrs_i[3] = 12'h333;
    tick();
    chk("lead_fptr", 32'(q.fanout_ptr_o), 32'h111);
    chk("lead_fcnt", 32'(q.fanout_cnt_o), 32'h2);
    chk("lead_valid", 32'(q.ptr_valid_o), 32'hA);
    q.pop_i = 4'b1010;
    tick();
    chk("lead_drain", 32'(q.ptr_valid_o), 32'h0);

    // Fill port 0, then overflow
    for (int i = 1; i <= 8; i++) begin
      q.write_reqs_i = 4'b0001;
      q.start_ptrs_i[0] = 12'(i);
      tick();
    end
    chk("p0_full", 32'(q.full_o), 32'h1);
    chk("p0_head", 32'(q.ptr_o[0]), 32'h1);
    q.write_reqs_i = 4'b0001;
    q.start_ptrs_i[0] = 12'h009;
    tick();
    chk("ovf_fvalid", 32'(q.fanout_valid_o), 32'h1);
    chk("ovf_fcnt", 32'(q.fanout_cnt_o), 32'h0);
    chk("ovf_fptr", 32'(q.fanout_ptr_o), 32'h009);
    chk("ovf_full", 32'(q.full_o), 32'h1);
    chk("ovf_head", 32'(q.ptr_o[0]), 32'h1);
`ifdef EGRESS_DROP_CNT_EN
    chk("ovf_drop0", 32'(drop_cnt[0]), 32'h1);
    chk("ovf_drop1", 32'(drop_cnt[1]), 32'h0);
`endif
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("p0_pop%0d", i), 32'(q.ptr_o[0]), 32'(i));
      q.pop_i = 4'b0001;
      tick();
    end
    chk("p0_empty", 32'(q.ptr_valid_o), 32'h0);
    chk("p0_notfull", 32'(q.full_o), 32'h0);

    // Port 1 full, push and pop in the same cycle
    for (int i = 1; i <= 8; i++) begin
      q.write_reqs_i = 4'b0010;
      q.start_ptrs_i[1] = 12'h100 + 12'(i);
      tick();
    end
    chk("p1_full", 32'(q.full_o), 32'h2);
    q.write_reqs_i = 4'b0010;
    q.pop_i = 4'b0010;
    q.start_ptrs_i[1] = 12'h00A;
    tick();
    chk("p1_pp_full", 32'(q.full_o), 32'h2);
    chk("p1_pp_head", 32'(q.ptr_o[1]), 32'h102);
    chk("p1_pp_fcnt", 32'(q.fanout_cnt_o), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("p1_pop%0d", i), 32'(q.ptr_o[1]), (i < 7) ? 32'h102 + 32'(i) : 32'h00A);
      q.pop_i = 4'b0010;
      tick();
    end
    chk("p1_empty", 32'(q.ptr_valid_o), 32'h0);

    // Streaming push+pop over 3*DEPTH entries to exercise index wrap
    for (int i = 0; i < 24; i++) begin
      q.write_reqs_i = 4'b0010;
      q.pop_i = (i > 0) ? 4'b0010 : 4'b0000;
      q.start_ptrs_i[1] = 12'h200 + 12'(i);
      tick();
      chk($sformatf("wrap_head%0d", i), 32'(q.ptr_o[1]), 32'h200 + 32'(i));
      chk($sformatf("wrap_valid%0d", i), 32'(q.ptr_valid_o), 32'h2);
    end
    q.pop_i = 4'b0010;
    tick();
    chk("wrap_empty", 32'(q.ptr_valid_o), 32'h0);

    // Pop on empty port 3, then push+pop on empty
    q.pop_i = 4'b1000;
    tick();
    chk("e3_valid", 32'(q.ptr_valid_o), 32'h0);
    chk("e3_full", 32'(q.full_o), 32'h0);
    q.write_reqs_i = 4'b1000;
    q.pop_i = 4'b1000;
    q.start_ptrs_i[3] = 12'h3C3;
    tick();
    chk("e3_pp_valid", 32'(q.ptr_valid_o), 32'h8);
    chk("e3_pp_head", 32'(q.ptr_o[3]), 32'h3C3);
    chk("e3_pp_fcnt", 32'(q.fanout_cnt_o), 32'h1);
    q.pop_i = 4'b1000;
    tick();
    chk("e3_drain", 32'(q.ptr_valid_o), 32'h0);

    // Reset with 5 entries queued; strobes in the reset cycle are ignored
    for (int i = 1; i <= 5; i++) begin
      q.write_reqs_i = 4'b0001;
      q.start_ptrs_i[0] = 12'h300 + 12'(i);
      tick();
    end
    chk("pre_rst_valid", 32'(q.ptr_valid_o), 32'h1);
    rst = 1'b1;
    q.write_reqs_i = 4'b0011;
    q.pop_i = 4'b0001;
    q.start_ptrs_i[0] = 12'h3FF;
    q.start_ptrs_i[1] = 12'h3FE;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(q.ptr_valid_o), 32'h0);
    chk("rst_full", 32'(q.full_o), 32'h0);
    chk("rst_fvalid", 32'(q.fanout_valid_o), 32'h0);
    chk("rst_fcnt", 32'(q.fanout_cnt_o), 32'h0);
    chk("rst_fptr", 32'(q.fanout_ptr_o), 32'h0);
`ifdef EGRESS_DROP_CNT_EN
    chk("rst_drop0", 32'(drop_cnt[0]), 32'h0);
`endif
    tick();
    chk("post_rst_valid", 32'(q.ptr_valid_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/egress_ptr_queue.md
# egress_ptr_queue

Per-port egress descriptor queues sitting directly downstream of the forwarding translator. Each cycle it accepts per-port write strobes carrying frame start pointers (one strobe per destination port, several at once when flooding), buffers them in one FIFO per egress port, and presents the head pointer to that port's frame reader under a valid/pop handshake. It also reports, one cycle later, how many queues actually accepted each frame so the buffer manager can set the frame's reference count.

## Interface
- NUM_PORTS, 4, number of egress ports (≥2)
- DEPTH, 8, pointer entries per port queue (power of two, ≥2)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- write_reqs_i  in  NUM_PORTS  per-port push strobe; each set bit is one push this cycle
- start_ptrs_i  in  NUM_PORTS×ADDR_W  pointer for each port's push, valid where the strobe is set
- pop_i  in  NUM_PORTS  per-port consume of the head entry
- ptr_o  out  NUM_PORTS×ADDR_W  head pointer of each queue
- ptr_valid_o  out  NUM_PORTS  queue non-empty
- full_o  out  NUM_PORTS  queue holds DEPTH entries
- fanout_valid_o  out  1  fanout report valid
- fanout_ptr_o  out  ADDR_W  pointer of the reported frame
- fanout_cnt_o  out  $clog2(NUM_PORTS+1)  number of queues that accepted the frame
- drop_cnt_o  out  NUM_PORTS×16  per-port dropped-push counters (present only with EGRESS_DROP_CNT_EN)

## Operation
- Each port queue: circular buffer, read/write indices $clog2(DEPTH) bits wrapping modulo DEPTH, occupancy count $clog2(DEPTH)+1 bits.
- Show-ahead: ptr_o[p] is the entry at the read index; ptr_valid_o[p] = count≠0; full_o[p] = count==DEPTH.
- Push accepted when write_reqs_i[p] && (!full || pop accepted same cycle).
- Pop accepted when pop_i[p] && ptr_valid_o[p]; pop on empty ignored, no state change.
- Push and pop same cycle: both occur, count unchanged; on an empty queue the push proceeds and the pop is ignored.
- Push on full with no pop: dropped; queue unchanged; drop counter +1 (with macro).
- Ports are fully independent; any subset may push/pop in one cycle.
- Fanout: in any cycle with write_reqs_i≠0, register fanout_valid_o=1, fanout_cnt_o=number of accepted pushes (0 allowed), fanout_ptr_o=start_ptrs_i of the lowest-indexed requesting port. Cycles with write_reqs_i==0 register fanout_valid_o=0.
- Reset: all counts/indices 0, ptr_valid_o 0, full_o 0, fanout_valid_o 0, fanout_cnt_o 0, fanout_ptr_o 0, drop counters 0. Storage contents not reset; ptr_o don't-care while ptr_valid_o is low.
- Reset asserted mid-operation discards all queued pointers in the same edge; pushes/pops in that cycle are ignored.

## Timing
- Push at edge N: ptr_valid_o/ptr_o updated and visible after edge N (1-cycle latency).
- Pop at edge N: next entry (or ptr_valid_o=0) visible after edge N.
- full_o and ptr_valid_o are functions of registered count only; no combinational path from inputs to outputs.
- Fanout report: registered, appears the cycle after the strobe cycle, valid for one cycle.
- Sustained throughput: one push and one pop per port per cycle.

## Configuration
- EGRESS_DROP_CNT_EN defined: drop_cnt_o present; each counter increments on a dropped push, saturates at 0xFFFF, clears only on rst.
- Undefined: drop_cnt_o port and counters absent; drops remain silent apart from fanout_cnt_o.

## Structure
- mem_pkg supplies ADDR_W; add a DROP_CNT_W=16 constant there.
- One sub-module, ptr_fifo (single-port show-ahead FIFO, DEPTH entries of ADDR_W, push/pop/full/valid/drop-strobe), instantiated NUM_PORTS times via generate; top adds fanout popcount and optional drop counters.

## Test plan
- Reset, then push 0x010 to port 2 -> next cycle ptr_valid_o=4'b0100, ptr_o[2]=0x010, fanout_valid_o=1, fanout_cnt_o=1, fanout_ptr_o=0x010.
- Flood write_reqs_i=4'b1111 with 0x020 all ports -> each queue head 0x020, fanout_cnt_o=4.
- Push 8 pointers 0x1..0x8 to port 0, then 0x9 -> full_o[0]=1, 0x9 dropped, fanout_cnt_o=0, drop_cnt_o[0]=1; pops return 0x1..0x8 in order.
- Port 1 full, push 0xA plus pop same cycle -> count stays 8, 0xA becomes last entry; wrap-around of indices checked over 3×DEPTH pushes.
- Pop on empty port 3 -> no change, ptr_valid_o[3] stays 0; simultaneous push+pop on empty -> entry retained.
- Assert rst with 5 entries queued -> next cycle all ptr_valid_o=0, full_o=0, drop counters 0.
